// File: rtl/fir_seq_filter.sv
// fir_seq_filter: sequential (one MAC per cycle) signed FIR filter.
// A start pulse in IDLE pushes datain into a TAPS-deep delay line. The FSM then
// runs TAPS multiply-accumulate cycles and presents the result in a DONE cycle.
// Coefficients are written through a simple strobe/address/data port while idle.
// Optional feature macro: FIR_SEQ_SAT_EN. When it is defined, dataout saturates
// to the DW signed range. Otherwise dataout keeps the low DW bits (wrap).
module fir_seq_filter #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int TAPS  = 8,
    parameter int SHIFT = 7,
    localparam int AW   = DW + CW + $clog2(TAPS),
    localparam int ABW  = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] datain,
    input  logic                 coef_we,
    input  logic [ABW-1:0]       coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW-1:0] dataout,
    output logic signed [AW-1:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ABW:0]   TAPS_L   = (ABW + 1)'(TAPS);
    localparam logic [ABW-1:0] TAP_LAST = ABW'(TAPS - 1);

`ifdef FIR_SEQ_SAT_EN
    localparam logic signed [AW-1:0] DMAX = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW-1:0] DMIN = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
`endif

    state_t                state_q, state_d;
    logic [ABW-1:0]        tap_q, tap_d;
    logic signed [AW-1:0]  mac_q, mac_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]  dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic signed [DW-1:0]  x_q    [TAPS];
    logic signed [DW-1:0]  x_d    [TAPS];
    logic signed [CW-1:0]  coef_q [TAPS];
    logic signed [CW-1:0]  coef_d [TAPS];
    logic signed [DW+CW-1:0] prod_s;

    // Scale the full-precision sum down to the output width.
    function automatic logic signed [DW-1:0] reduce_out(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] sh;
        sh = v >>> SHIFT;
`ifdef FIR_SEQ_SAT_EN
        if (sh > DMAX) begin
            return DMAX[DW-1:0];
        end else if (sh < DMIN) begin
            return DMIN[DW-1:0];
        end else begin
            return sh[DW-1:0];
        end
`else
        return sh[DW-1:0];
`endif
    endfunction

    // Product of the current tap; AW leaves clog2(TAPS) guard bits so the sum cannot overflow.
    always_comb begin
        prod_s = coef_q[tap_q] * x_q[tap_q];
    end

    // Next-state logic for the FSM, delay line, coefficient bank and outputs.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        mac_d   = mac_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            x_d[i]    = x_q[i];
            coef_d[i] = coef_q[i];
        end
        case (state_q)
            S_IDLE: begin
                // The coefficient write lands on the same edge as start, so the MAC sees it.
                if (coef_we && ({1'b0, coef_addr} < TAPS_L)) begin
                    coef_d[coef_addr] = coef_data;
                end else begin
                    coef_d[0] = coef_q[0];
                end
                if (start) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i - 1];
                    end
                    x_d[0]  = datain;
                    mac_d   = {AW{1'b0}};
                    tap_d   = {ABW{1'b0}};
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                mac_d = mac_q + {{(AW - DW - CW){prod_s[DW+CW-1]}}, prod_s};
                if (tap_q == TAP_LAST) begin
                    state_d = S_DONE;
                end else begin
                    tap_d = tap_q + ABW'(1);
                end
            end
            S_DONE: begin
                acc_d   = mac_q;
                dout_d  = reduce_out(mac_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers with asynchronous clear of every storage element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tap_q   <= {ABW{1'b0}};
            mac_q   <= {AW{1'b0}};
            acc_q   <= {AW{1'b0}};
            dout_q  <= {DW{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= {DW{1'b0}};
                coef_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            mac_q   <= mac_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= x_d[i];
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dataout = dout_q;
    assign acc     = acc_q;

endmodule

// File: tb/tb_fir_seq_filter.sv
// Self-checking bench for fir_seq_filter. Two instances share their inputs:
// one with SHIFT=0 and one with SHIFT=7. A plain arithmetic reference model
// (sample array, coefficient array, dot product) predicts every result.
module tb_fir_seq_filter;

    localparam int TAPS = 8;
    localparam int AW   = 19;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic signed [7:0] datain = 8'sd0;
    logic              coef_we = 1'b0;
    logic [2:0]        coef_addr = 3'd0;
    logic signed [7:0] coef_data = 8'sd0;

    logic              busy0, done0, busy7, done7;
    logic signed [7:0] dout0, dout7;
    logic signed [AW-1:0] acc0, acc7;

    int checks = 0;
    int errors = 0;

    // reference model state
    int xm [TAPS];
    int cm [TAPS];
    longint last_sum;

    always #5 clk = ~clk;

    fir_seq_filter #(.DW(8), .CW(8), .TAPS(TAPS), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .datain(datain),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy0), .done(done0), .dataout(dout0), .acc(acc0)
    );

    fir_seq_filter #(.DW(8), .CW(8), .TAPS(TAPS), .SHIFT(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start), .datain(datain),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy7), .done(done7), .dataout(dout7), .acc(acc7)
    );

    function automatic logic [7:0] model_dout(input longint a, input int sh);
        longint s;
        s = a >>> sh;
`ifdef FIR_SEQ_SAT_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    function automatic longint model_sum();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(cm[k]) * longint'(xm[k]);
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            xm[k] = 0;
            cm[k] = 0;
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we = 1'b1; coef_addr = 3'(addr); coef_data = 8'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
        cm[addr] = val;
    endtask

    // Waits for done, bounded; n = edges after the start edge, -1 on timeout.
    task automatic wait_done(output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < 30) begin
            @(posedge clk); #1;
            i++;
            if (done0) n = i;
        end
    endtask

    task automatic check_result(input string nm);
        logic [AW-1:0] e;
        e = last_sum[AW-1:0];
        checks++;
        if (acc0 !== e) begin errors++; $display("FAIL %s acc0 got %0d exp %0d", nm, acc0, $signed(e)); end
        checks++;
        if (dout0 !== model_dout(last_sum, 0)) begin errors++; $display("FAIL %s dout0 got %h exp %h", nm, dout0, model_dout(last_sum, 0)); end
        checks++;
        if (acc7 !== e || dout7 !== model_dout(last_sum, 7)) begin
            errors++; $display("FAIL %s sh7 got acc %0d dout %h exp acc %0d dout %h", nm, acc7, dout7, $signed(e), model_dout(last_sum, 7));
        end
    endtask

    // One complete sample: optional same-cycle coefficient write, start, latency and result checks.
    task automatic run_start(input int din, input bit we, input int addr, input int val, input string nm);
        int n;
        start = 1'b1; datain = 8'(din);
        coef_we = we; coef_addr = 3'(addr); coef_data = 8'(val);
        @(posedge clk); #1;
        start = 1'b0; coef_we = 1'b0;
        if (we) cm[addr] = val;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = din;
        last_sum = model_sum();
        checks++;
        if (busy0 !== 1'b1 || busy7 !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b exp 1", nm, busy0); end
        wait_done(n);
        checks++;
        if (n != TAPS + 1 || done7 !== 1'b1) begin errors++; $display("FAIL %s latency got %0d exp %0d", nm, n, TAPS + 1); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b exp 0", nm, busy0); end
        check_result(nm);
        @(posedge clk); #1;
        checks++;
        if (done0 !== 1'b0 || acc0 !== last_sum[AW-1:0]) begin
            errors++; $display("FAIL %s hold got done %b acc %0d exp done 0 acc %0d", nm, done0, acc0, last_sum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || acc0 !== '0 || dout0 !== 8'h00 ||
            busy7 !== 1'b0 || done7 !== 1'b0 || acc7 !== '0 || dout7 !== 8'h00) begin
            errors++; $display("FAIL reset got busy %b done %b acc %0d dout %h exp all 0", busy0, done0, acc0, dout0);
        end
    endtask

    task automatic test_impulse();
        int exp_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        for (int s = 0; s < 9; s++) begin
            run_start((s == 0) ? 1 : 0, 1'b0, 0, 0, "impulse");
            checks++;
            if (acc0 !== 19'(exp_seq[s])) begin errors++; $display("FAIL impulse_seq[%0d] got %0d exp %0d", s, acc0, exp_seq[s]); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_d;
        for (int k = 0; k < TAPS; k++) write_coef(k, 127);
        for (int s = 0; s < 8; s++) run_start(127, 1'b0, 0, 0, "saturation");
`ifdef FIR_SEQ_SAT_EN
        exp_d = 8'h7F;
`else
        exp_d = 8'h08;
`endif
        checks++;
        if (acc0 !== 19'd129032 || dout0 !== exp_d) begin
            errors++; $display("FAIL saturation_const got acc %0d dout %h exp acc 129032 dout %h", acc0, dout0, exp_d);
        end
    endtask

    task automatic test_negative();
        write_coef(0, -2);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        run_start(-3, 1'b0, 0, 0, "negative");
        checks++;
        if (acc0 !== 19'sd6 || dout0 !== 8'h06) begin errors++; $display("FAIL negative_const got acc %0d dout %h exp 6 06", acc0, dout0); end
    endtask

    task automatic test_busy_guard();
        int n;
        int extra;
        for (int k = 0; k < TAPS; k++) write_coef(k, $urandom_range(0, 255) - 128);
        start = 1'b1; datain = 8'sd17;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = 17;
        last_sum = model_sum();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; datain = 8'sd55; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'sd99;
        @(posedge clk); #1;
        start = 1'b0; coef_we = 1'b0;
        wait_done(n);
        checks++;
        if (n != TAPS + 1 - 4) begin errors++; $display("FAIL busy_guard_latency got %0d exp %0d", n, TAPS - 3); end
        check_result("busy_guard");
        extra = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done0 || done7) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL busy_guard_extra_done got %0d exp 0", extra); end
        run_start(-9, 1'b0, 0, 0, "busy_guard_after");
    endtask

    task automatic test_simultaneous();
        run_start(100, 1'b1, 0, -77, "simul_we_start");
        run_start(-50, 1'b1, 5, 33, "simul_we_start2");
    endtask

    task automatic test_reset_mid_mac();
        int extra;
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 3);
        run_start(40, 1'b0, 0, 0, "pre_reset");
        start = 1'b1; datain = 8'sd60;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        model_clear();
        #2;
        checks++;
        if (acc0 !== '0 || dout0 !== 8'h00 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL reset_mid got acc %0d dout %h busy %b done %b exp 0", acc0, dout0, busy0, done0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        extra = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done0 || done7) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL reset_mid_done got %0d exp 0", extra); end
        for (int k = 0; k < TAPS; k++) write_coef(k, 1);
        run_start(5, 1'b0, 0, 0, "post_reset");
        checks++;
        if (acc0 !== 19'sd5) begin errors++; $display("FAIL post_reset_const got %0d exp 5", acc0); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) write_coef($urandom_range(0, TAPS - 1), $urandom_range(0, 255) - 128);
            run_start($urandom_range(0, 255) - 128, 1'($urandom_range(0, 1)),
                      $urandom_range(0, TAPS - 1), $urandom_range(0, 255) - 128, "random");
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_saturation();
        test_negative();
        test_busy_guard();
        test_simultaneous();
        test_reset_mid_mac();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
